// File: rtl/noc_send_arbiter.sv
// Round-robin arbiter sharing one PE-to-router send interface between
// N_REQ local requesters. The granted requester keeps the interface for a
// whole header + seq_len data beats; priority rotates past it afterwards.
module noc_send_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         local_id,

    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_dst_i,
    input  logic [N_REQ*LEN_W-1:0]    req_len_i,
    input  logic [N_REQ*ID_W-1:0]     req_id_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          rdy_o,
    output logic [N_REQ-1:0]          done_o,

    output logic                      o_comm_send_req,
    input  logic                      i_comm_send_ack,
    output logic [ADDR_W-1:0]         o_src,
    output logic [ADDR_W-1:0]         o_dst,
    output logic [LEN_W-1:0]          o_seq_len,
    output logic [ID_W-1:0]           o_id,
    output logic                      o_data_valid,
    output logic [DATA_W-1:0]         o_data,
    input  logic                      i_if_ready
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] ptr;       // requester with highest priority next round
    logic [IDX_W-1:0] g;         // currently granted requester
    logic [IDX_W-1:0] pick;      // arbitration winner this cycle
    logic             pick_vld;
    logic [LEN_W-1:0] cnt;       // beats still to forward
    logic             beat;      // one data beat transfers this cycle
    int               idx;

    // Round-robin search: first set request at or after ptr, wrapping.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_i[IDX_W'(idx)]) begin
                pick     = IDX_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic plus the combinational handshake and beat path.
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next      = state;
        o_comm_send_req = 1'b0;
        o_data_valid    = 1'b0;
        o_data          = '0;
        rdy_o           = '0;
        done_o          = '0;
        beat            = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_vld) state_next = S_HDR;
            end
            S_HDR: begin
                o_comm_send_req = 1'b1;
                if (i_comm_send_ack)
                    state_next = (cnt != '0) ? S_DATA : S_DONE;
            end
            S_DATA: begin
                beat         = req_valid_i[g] & i_if_ready;
                o_data_valid = beat;
                o_data       = req_data_i[g*DATA_W +: DATA_W];
                rdy_o[g]     = beat;
                if (beat && cnt == LEN_W'(1)) state_next = S_DONE;
            end
            S_DONE: begin
                done_o[g]  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Grant, header latch, beat counter and priority pointer.
    // The header is captured once at grant so it stays stable through HDR
    // even if the requester changes its fields or drops its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            g         <= '0;
            cnt       <= '0;
            gnt_o     <= '0;
            o_src     <= '0;
            o_dst     <= '0;
            o_seq_len <= '0;
            o_id      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        g         <= pick;
                        gnt_o     <= N_REQ'(1) << pick;
                        o_src     <= local_id;
                        o_dst     <= req_dst_i[pick*ADDR_W +: ADDR_W];
                        o_seq_len <= req_len_i[pick*LEN_W +: LEN_W];
                        o_id      <= req_id_i[pick*ID_W +: ID_W];
                        cnt       <= req_len_i[pick*LEN_W +: LEN_W];
                    end
                end
                S_DATA: begin
                    // DATA is only entered with cnt >= 1 and left on the
                    // beat that takes it to 0, so this cannot underflow.
                    if (beat) cnt <= cnt - LEN_W'(1);
                end
                S_DONE: begin
                    gnt_o <= '0;
                    ptr   <= (g == IDX_W'(N_REQ - 1)) ? '0 : g + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_send_arbiter.sv
// Scoreboard bench for noc_send_arbiter: each test pushes the expected
// headers and data beats when it raises requests; a negedge monitor pops
// and compares them as the arbiter emits them.
module tb_noc_send_arbiter;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 8;
    localparam int ID_W   = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
        logic [N_REQ-1:0]  gnt;
    } hdr_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [ADDR_W-1:0]       local_id;
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ*ADDR_W-1:0] req_dst_i;
    logic [N_REQ*LEN_W-1:0]  req_len_i;
    logic [N_REQ*ID_W-1:0]   req_id_i;
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ*DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0]        gnt_o, rdy_o, done_o;
    logic                    o_comm_send_req;
    logic                    i_comm_send_ack;
    logic [ADDR_W-1:0]       o_src, o_dst;
    logic [LEN_W-1:0]        o_seq_len;
    logic [ID_W-1:0]         o_id;
    logic                    o_data_valid;
    logic [DATA_W-1:0]       o_data;
    logic                    i_if_ready;

    noc_send_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst), .local_id(local_id),
        .req_i(req_i), .req_dst_i(req_dst_i), .req_len_i(req_len_i),
        .req_id_i(req_id_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .gnt_o(gnt_o), .rdy_o(rdy_o), .done_o(done_o),
        .o_comm_send_req(o_comm_send_req), .i_comm_send_ack(i_comm_send_ack),
        .o_src(o_src), .o_dst(o_dst), .o_seq_len(o_seq_len), .o_id(o_id),
        .o_data_valid(o_data_valid), .o_data(o_data), .i_if_ready(i_if_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-requester stimulus fields.
    logic [ADDR_W-1:0] dst_a [N_REQ];
    logic [LEN_W-1:0]  len_a [N_REQ];
    logic [ID_W-1:0]   id_a  [N_REQ];
    int unsigned       bcnt    [N_REQ];   // driver: beats already accepted
    int unsigned       model_b [N_REQ];   // model: beats already expected

    function automatic logic [DATA_W-1:0] data_of(input int k, input int unsigned b);
        return {8'hD0, k[7:0], b[15:0]};
    endfunction

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            req_dst_i[k*ADDR_W +: ADDR_W] = dst_a[k];
            req_len_i[k*LEN_W +: LEN_W]   = len_a[k];
            req_id_i[k*ID_W +: ID_W]      = id_a[k];
            req_data_i[k*DATA_W +: DATA_W] = data_of(k, bcnt[k]);
        end
    end

    // Scoreboard queues and knobs.
    hdr_t            hdr_q[$];
    logic [DATA_W-1:0] data_q[$];
    int  ack_delay = 0;
    int  ready_mode = 0;          // 0: always ready, 1: toggle, 2: never
    bit  bubble_en = 0, bubble_done = 0, abort_en = 0;
    int  hold = 0, hw = 0;

    // Monitor state.
    int  cyc = 0, hdr_wait = 0, beats_in_seq = 0, beat_total = 0, done_cnt = 0;
    int  ack_cyc = 0, last_beat_cyc = 0;
    bit  idle_chk = 0;
    hdr_t cur = '0;
    logic [N_REQ-1:0] rdy_seen = '0;

    // Interface-side driver: ack, ready, valid bubbles, data advance.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N_REQ; k++) if (rdy_seen[k]) bcnt[k]++;
        rdy_seen = '0;
        if (o_comm_send_req) hw++; else hw = 0;
        // Outside HDR the ack is random noise the arbiter must ignore.
        i_comm_send_ack = o_comm_send_req ? (hw > ack_delay) : 1'($urandom_range(0, 1));
        if (bubble_en && !bubble_done && beats_in_seq == 1) begin
            hold = 2;
            bubble_done = 1;
        end
        req_valid_i = (hold > 0) ? '0 : '1;
        if (hold > 0) hold--;
        case (ready_mode)
            0:       i_if_ready = 1'b1;
            1:       i_if_ready = ~i_if_ready;
            default: i_if_ready = 1'b0;
        endcase
        if (abort_en && beats_in_seq >= 1) i_if_ready = 1'b0;
    end

    // Monitor: compares header, beats and done pulses against the queues.
    always @(negedge clk) begin
        cyc++;
        rdy_seen = rdy_seen | rdy_o;
        if (!rst) begin
            if (idle_chk) begin
                check("idle_after_done", {gnt_o, o_comm_send_req}, '0);
                idle_chk = 0;
            end
            if (o_comm_send_req) begin
                hdr_wait++;
                if (hdr_q.size() == 0) check("hdr_unexpected", 1, 0);
                else begin
                    check("hdr_fields", {o_src, o_dst, o_seq_len, o_id, gnt_o}, hdr_q[0]);
                    if (i_comm_send_ack) begin
                        check("ack_wait", hdr_wait, ack_delay + 1);
                        cur = hdr_q.pop_front();
                        ack_cyc = cyc;
                        beats_in_seq = 0;
                    end
                end
            end else hdr_wait = 0;
            if (o_data_valid) begin
                beats_in_seq++;
                beat_total++;
                last_beat_cyc = cyc;
                check("rdy_owner", rdy_o, cur.gnt);
                check("beat_handshake", i_if_ready & |(req_valid_i & cur.gnt), 1);
                if (data_q.size() == 0) check("beat_unexpected", 1, 0);
                else check("beat_data", o_data, data_q.pop_front());
            end else check("rdy_quiet", rdy_o, 0);
            if (done_o != '0) begin
                done_cnt++;
                idle_chk = 1;
                check("done_owner", done_o, cur.gnt);
                check("beat_count", beats_in_seq, cur.len);
                check("done_latency", cyc - ((cur.len == 0) ? ack_cyc : last_beat_cyc), 1);
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return 64'({gnt_o, rdy_o, done_o, o_comm_send_req, o_src, o_dst,
                    o_seq_len, o_id, o_data_valid, o_data});
    endfunction

    task automatic set_req(input int k, input int dst, input int len, input int id);
        dst_a[k] = ADDR_W'(dst);
        len_a[k] = LEN_W'(len);
        id_a[k]  = ID_W'(id);
    endtask

    task automatic expect_seq(input int k);
        hdr_t h;
        h.src = local_id;
        h.dst = dst_a[k];
        h.len = len_a[k];
        h.id  = id_a[k];
        h.gnt = N_REQ'(1) << k;
        hdr_q.push_back(h);
        for (int b = 0; b < int'(len_a[k]); b++) begin
            data_q.push_back(data_of(k, model_b[k]));
            model_b[k]++;
        end
    endtask

    // Pulse a request for one cycle: it is seen in IDLE, then dropped once
    // the grant is up, relying on the grant being sticky.
    task automatic pulse_req(input logic [N_REQ-1:0] mask);
        @(posedge clk); #1;
        req_i = mask;
        @(posedge clk); #1;
        req_i = '0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int target;
        target = done_cnt + n;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt >= target) return;
        end
        check("done_timeout", done_cnt, target);
    endtask

    initial begin
        int saved_done, saved_beats;
        rst = 1'b1;
        req_i = '0;
        local_id = ADDR_W'(1);
        i_comm_send_ack = 1'b0;
        i_if_ready = 1'b1;
        req_valid_i = '1;
        for (int k = 0; k < N_REQ; k++) begin
            set_req(k, 0, 0, 0);
            bcnt[k] = 0;
            model_b[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), '0);
        rst = 1'b0;

        // Single request after reset, ack one cycle late, ready always.
        set_req(0, 5, 3, 2);
        ack_delay = 1;
        expect_seq(0);
        @(posedge clk); #1;
        req_i = 2'b01;
        check("req_before_grant", o_comm_send_req, 0);
        @(posedge clk); #1;
        check("req_latency", {o_comm_send_req, gnt_o}, {1'b1, 2'b01});
        req_i = '0;
        wait_done(1, 50);

        // Contention: both held; ptr now points at requester 1.
        set_req(0, 3, 2, 4);
        set_req(1, 6, 2, 5);
        ack_delay = 0;
        expect_seq(1);
        expect_seq(0);
        expect_seq(1);
        expect_seq(0);
        @(posedge clk); #1;
        req_i = 2'b11;
        wait_done(4, 200);
        req_i = '0;

        // Backpressure: ready toggles, valid drops 2 cycles after beat 1.
        set_req(1, 9, 4, 7);
        ready_mode = 1;
        bubble_en = 1;
        bubble_done = 0;
        expect_seq(1);
        pulse_req(2'b10);
        wait_done(1, 100);
        ready_mode = 0;
        bubble_en = 0;

        // Zero length: header only.
        set_req(1, 2, 0, 9);
        expect_seq(1);
        pulse_req(2'b10);
        wait_done(1, 50);

        // Late ack with the request dropped in HDR.
        set_req(0, 12, 1, 3);
        ack_delay = 5;
        expect_seq(0);
        pulse_req(2'b01);
        wait_done(1, 100);
        ack_delay = 0;

        // Reset mid-DATA after 1 of 3 beats; ptr is 1 before the reset.
        set_req(1, 4, 3, 1);
        expect_seq(1);
        abort_en = 1;
        saved_beats = beat_total;
        saved_done = done_cnt;
        pulse_req(2'b10);
        for (int i = 0; i < 50 && beat_total == saved_beats; i++) begin
            @(posedge clk); #1;
        end
        check("abort_first_beat", beat_total, saved_beats + 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_data", all_outs(), '0);
        rst = 1'b0;
        abort_en = 0;
        data_q.delete();
        model_b[1] = model_b[1] - 2;
        check("no_done_on_abort", done_cnt, saved_done);

        // After reset requester 0 has priority again.
        set_req(0, 7, 1, 6);
        set_req(1, 8, 1, 7);
        expect_seq(0);
        expect_seq(1);
        @(posedge clk); #1;
        req_i = 2'b11;
        wait_done(2, 100);
        req_i = '0;

        repeat (4) @(posedge clk);
        #1;
        check("hdr_q_drained", hdr_q.size(), 0);
        check("data_q_drained", data_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/noc_send_arbiter.md
# noc_send_arbiter

Round-robin arbiter that shares one node's single PE-to-router send interface (`comm_send_req`/`ack`, `data_valid`/`data`, `src`/`dst`/`seq_len`/`id`) between N local requesters, e.g. master PE and mig_office. It sits between the requesters and the interface-to-router block. It runs the request/ack handshake for the granted requester and forwards exactly `seq_len` data beats. It holds the grant until the packet sequence is complete, then rotates priority.

## Interface
- `N_REQ`, default 2: number of requesters.
- `DATA_W`, default 32: data beat width.
- `ADDR_W`, default 4: node address width (src/dst).
- `LEN_W`, default 8: sequence-length width.
- `ID_W`, default 4: transaction id width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `local_id`  in  ADDR_W  this node's address; driven onto `o_src`.
- `req_i`  in  N_REQ  per-requester send request (level).
- `req_dst_i`  in  N_REQ*ADDR_W  destination per requester, packed (requester k at bits [k*ADDR_W +: ADDR_W]).
- `req_len_i`  in  N_REQ*LEN_W  beat count per requester, packed.
- `req_id_i`  in  N_REQ*ID_W  transaction id per requester, packed.
- `req_valid_i`  in  N_REQ  data beat valid per requester.
- `req_data_i`  in  N_REQ*DATA_W  data per requester, packed.
- `gnt_o`  out  N_REQ  one-hot grant, registered.
- `rdy_o`  out  N_REQ  beat accepted this cycle for the granted requester.
- `done_o`  out  N_REQ  one-cycle pulse when the requester's sequence is complete.
- `o_comm_send_req`  out  1  send request to the interface.
- `i_comm_send_ack`  in  1  interface accepts the header.
- `o_src`/`o_dst`/`o_seq_len`/`o_id`  out  ADDR_W/ADDR_W/LEN_W/ID_W  header, registered at grant.
- `o_data_valid`  out  1  beat valid to the interface.
- `o_data`  out  DATA_W  beat data.
- `i_if_ready`  in  1  interface can take a beat this cycle.

## Operation
- States: IDLE, HDR, DATA, DONE.
- **IDLE:**
  - If any `req_i` is set, pick the first set bit searching upward (with wrap) from `ptr`.
  - Latch the grant index, `req_dst_i`/`req_len_i`/`req_id_i` of the winner and `local_id` into header registers.
  - Load `cnt` = len. Set `gnt_o`. Go to HDR.
- **HDR:**
  - Assert `o_comm_send_req` with the header stable.
  - Hold until `i_comm_send_ack` = 1.
  - On ack: go to DATA if `cnt` != 0, else go to DONE.
- **DATA:**
  - `o_data` = `req_data_i` of the granted requester (combinational mux).
  - `o_data_valid` = `req_valid_i[g] & i_if_ready`.
  - `rdy_o[g]` = `req_valid_i[g] & i_if_ready`.
  - Each beat transfer decrements `cnt`. The transfer where `cnt` = 1 is the last beat; go to DONE.
- **DONE:**
  - Pulse `done_o[g]`.
  - Set `ptr` = g+1 (mod N_REQ). Clear `gnt_o`. Go to IDLE.
- The grant is sticky: deasserting `req_i[g]` after grant has no effect. The sequence completes only by beats.
- Requests from non-granted requesters are held off: their `rdy_o` stays 0 and `done_o` stays 0.
- `cnt` is LEN_W bits, unsigned, and never underflows. `seq_len` = 0 is legal: header only, no data phase.

## Timing
- Reset values: state IDLE, `ptr` = 0, `cnt` = 0, all outputs 0, including header registers.
- Reset mid-sequence aborts immediately. No `done_o` is issued.
- Request-to-`o_comm_send_req` latency: 1 cycle. `req_i` is seen in IDLE in cycle t; HDR and the grant appear in t+1.
- Ack seen in cycle t gives DATA in t+1. The first beat can transfer in t+1.
- The beat path adds zero latency: valid, ready and data are combinational in DATA.
- Last beat in cycle t gives DONE in t+1 and IDLE in t+2.
- The next grant appears at t+3 at the earliest. Minimum header-only turnaround is 3 cycles.
- `o_comm_send_req` deasserts the cycle after ack.
- `i_comm_send_ack` outside HDR is ignored.
- Simultaneous requests resolve by `ptr` priority only.
- N_REQ = 1 degenerates to a plain sequencer with `ptr` fixed at 0.

## Test plan
- **Single request after reset:**
  - Stimulus: `req_i` = 01, len = 3, dst = 5, id = 2, `local_id` = 1, ack one cycle after `o_comm_send_req`, `i_if_ready` = 1.
  - Required: header src = 1, dst = 5, seq_len = 3, id = 2. Exactly 3 `o_data_valid` beats carrying requester-0 data. `done_o` = 01 pulse. IDLE 2 cycles after the last beat.
- **Contention fairness:**
  - Stimulus: `req_i` = 11 held continuously, len = 2 each.
  - Required: grants alternate 01, 10, 01, 10. No two consecutive sequences go to the same requester.
- **Backpressure and bubbles:**
  - Stimulus: len = 4, `i_if_ready` toggles 1,0,1,0… and `req_valid_i` drops for 2 cycles mid-sequence.
  - Required: only cycles with valid & ready transfer. Exactly 4 beats. Data order preserved.
- **Zero length:**
  - Stimulus: len = 0.
  - Required: HDR→DONE on ack with no `o_data_valid`. `done_o` pulses 1 cycle after ack.
- **Late ack and sticky grant:**
  - Stimulus: ack delayed 5 cycles; `req_i[g]` dropped in HDR.
  - Required: `o_comm_send_req` and the header are stable for all 5 cycles, and the sequence still completes.
- **Reset mid-DATA:**
  - Stimulus: assert `rst` after 1 of 3 beats.
  - Required: next cycle all outputs are 0, state IDLE and `ptr` = 0. No `done_o`. A new request restarts cleanly with requester 0 having priority.
